encaps_rq_engine: RTL and testbench

- Parametrised, handshake-driven successor to the fixed-width encapsulation datapath.
- Computes c = r*h + Lift(m) in Rq = Z_(2^LOGQ)[x]/(x^N - 1).
- h, r and m are streamed in coefficient-serially; c is streamed out coefficient-serially under backpressure.
- Sits between the unpack/sampling front end and the ciphertext packer. Supports a selectable lift mode and optional Rq0 last-coefficient drop.

---
 rtl/encaps_pkg.sv | 30 +++
 rtl/rq_rot_mac.sv | 66 ++++++
 rtl/encaps_rq_engine.sv | 157 +++++++++++++++
 tb/tb_encaps_rq_engine.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/encaps_pkg.sv
// Shared definitions for the Rq encapsulation engine.
// Ternary coefficient codes, FSM state type and ternary-to-Rq lift helper.
// No ports; imported by encaps_rq_engine and rq_rot_mac.
package encaps_pkg;

   // Ternary coefficient codes as they arrive on in_r / in_m (2'b11 reads as zero)
   localparam logic [1:0] TER_ZERO = 2'b00;
   localparam logic [1:0] TER_POS  = 2'b01;
   localparam logic [1:0] TER_NEG  = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LOAD = 3'd1,
      ST_MUL  = 3'd2,
      ST_LIFT = 3'd3,
      ST_OUT  = 3'd4
   } state_t;

   // Maps a ternary code to {0, 1, q-1} with q = 2^logq; caller truncates to LOGQ bits.
   function automatic logic [31:0] ter_to_rq(input logic [1:0] code, input int logq);
      logic [31:0] v;
      case (code)
         TER_POS: v = 32'd1;
         TER_NEG: v = (32'd1 << logq) - 32'd1;
         default: v = 32'd0;
      endcase
      return v;
   endfunction

endpackage

// File: rtl/rq_rot_mac.sv
// N-lane Rq accumulator with a rotating copy of h: acc[k] +/-= hrot[k] per enabled cycle.
// Latency: one clk per MAC/rotate step, one clk for the lift add; acc visible the cycle after.
// Backpressure: none; sequencing is entirely driven by the enables from the owning FSM.
// Ports: ld_en/ld_idx/ld_h write h into hrot; rot_en rotates hrot by one lane;
//   acc_en/acc_neg add or subtract hrot into acc; lift_en adds lift_vec; clr zeroes acc;
//   acc_vec exposes all N accumulator lanes flattened (lane k at [k*LOGQ +: LOGQ]).
module rq_rot_mac #(
   parameter int N    = 701,
   parameter int LOGQ = 13,
   parameter int IW   = $clog2(N)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              ld_en,
   input  logic [IW-1:0]     ld_idx,
   input  logic [LOGQ-1:0]   ld_h,
   input  logic              rot_en,
   input  logic              acc_en,
   input  logic              acc_neg,
   input  logic              lift_en,
   input  logic [N*LOGQ-1:0] lift_vec,
   output logic [N*LOGQ-1:0] acc_vec
);

   logic [LOGQ-1:0] hrot [N];
   logic [LOGQ-1:0] acc  [N];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < N; k++) begin
            hrot[k] <= '0;
            acc[k]  <= '0;
         end
      end else begin
         if (ld_en) begin
            hrot[ld_idx] <= ld_h;
         end else if (rot_en) begin
            // After rotating i times, hrot[k] holds h[(k-i) mod N]
            for (int k = 0; k < N; k++) begin
               hrot[k] <= hrot[(k == 0) ? N-1 : k-1];
            end
         end

         if (clr) begin
            for (int k = 0; k < N; k++) acc[k] <= '0;
         end else if (acc_en) begin
            for (int k = 0; k < N; k++) begin
               acc[k] <= acc_neg ? acc[k] - hrot[k] : acc[k] + hrot[k];
            end
         end else if (lift_en) begin
            for (int k = 0; k < N; k++) begin
               acc[k] <= acc[k] + lift_vec[k*LOGQ +: LOGQ];
            end
         end
      end
   end

   genvar g;
   generate
      for (g = 0; g < N; g++) begin : g_acc_out
         assign acc_vec[g*LOGQ +: LOGQ] = acc[g];
      end
   endgenerate

endmodule

// File: rtl/encaps_rq_engine.sv
// Computes c = r*h + Lift(m) in Z_(2^LOGQ)[x]/(x^N - 1), coefficient-serial in and out.
// Latency: last input beat at edge E -> N MUL edges, one LIFT edge, out_valid high after E+N+1.
// Backpressure: in_ready only in IDLE/LOAD; out_c held stable while out_ready is low.
// Ports: clk, rst_n; mode (lift select, latched on first beat); in_valid/in_ready with
//   in_h/in_r/in_m operand beats; out_valid/out_ready with out_c/out_last; busy = not IDLE.
module encaps_rq_engine
   import encaps_pkg::*;
#(
   parameter int N         = 701,
   parameter int LOGQ      = 13,
   parameter int DROP_LAST = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            mode,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [LOGQ-1:0] in_h,
   input  logic [1:0]      in_r,
   input  logic [1:0]      in_m,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [LOGQ-1:0] out_c,
   output logic            out_last,
   output logic            busy
);

   localparam int IW = $clog2(N);
   localparam logic [IW-1:0] LAST_IDX = IW'(N-1);
   localparam logic [IW-1:0] OUT_LAST = IW'((DROP_LAST != 0) ? N-2 : N-1);

   state_t          state;
   logic [IW-1:0]   j;
   logic [IW-1:0]   i;
   logic [IW-1:0]   k;
   logic            mode_q;
   logic [1:0]      r_mem [N];
   logic [1:0]      m_mem [N];

   logic              in_fire;
   logic              out_fire;
   logic              acc_en;
   logic              acc_neg;
   logic              clr;
   logic [N*LOGQ-1:0] lift_vec;
   logic [N*LOGQ-1:0] acc_vec;

   // Gated by rst_n so the port reads 0 while reset is held, even though state is IDLE
   assign in_ready  = rst_n && ((state == ST_IDLE) || (state == ST_LOAD));
   assign in_fire   = in_valid && in_ready;
   assign out_valid = (state == ST_OUT);
   assign out_fire  = out_valid && out_ready;
   assign out_last  = out_valid && (k == OUT_LAST);
   assign out_c     = out_valid ? acc_vec[int'(k)*LOGQ +: LOGQ] : '0;
   assign busy      = (state != ST_IDLE);

   // r = 0 (or the unused 2'b11 code) still burns its MUL cycle, it just adds nothing
   assign acc_en  = (state == ST_MUL) && ((r_mem[i] == TER_POS) || (r_mem[i] == TER_NEG));
   assign acc_neg = (r_mem[i] == TER_NEG);
   assign clr     = out_fire && (k == OUT_LAST);

   // mode 0: plain ternary m; mode 1: m*(x-1), i.e. m[k-1] - m[k] cyclically
   always_comb begin
      lift_vec = '0;
      for (int n = 0; n < N; n++) begin
         if (mode_q) begin
            lift_vec[n*LOGQ +: LOGQ] = LOGQ'(ter_to_rq(m_mem[(n == 0) ? N-1 : n-1], LOGQ))
                                     - LOGQ'(ter_to_rq(m_mem[n], LOGQ));
         end else begin
            lift_vec[n*LOGQ +: LOGQ] = LOGQ'(ter_to_rq(m_mem[n], LOGQ));
         end
      end
   end

   // j is 0 in IDLE, so the first beat lands at index 0 through the same path as LOAD
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= ST_IDLE;
         j      <= '0;
         i      <= '0;
         k      <= '0;
         mode_q <= 1'b0;
         for (int n = 0; n < N; n++) begin
            r_mem[n] <= TER_ZERO;
            m_mem[n] <= TER_ZERO;
         end
      end else begin
         case (state)
            ST_IDLE: begin
               if (in_fire) begin
                  r_mem[j] <= in_r;
                  m_mem[j] <= in_m;
                  mode_q   <= mode;
                  j        <= j + IW'(1);
                  state    <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               if (in_fire) begin
                  r_mem[j] <= in_r;
                  m_mem[j] <= in_m;
                  if (j == LAST_IDX) begin
                     j     <= '0;
                     i     <= '0;
                     state <= ST_MUL;
                  end else begin
                     j <= j + IW'(1);
                  end
               end
            end
            ST_MUL: begin
               if (i == LAST_IDX) begin
                  i     <= '0;
                  state <= ST_LIFT;
               end else begin
                  i <= i + IW'(1);
               end
            end
            ST_LIFT: begin
               k     <= '0;
               state <= ST_OUT;
            end
            ST_OUT: begin
               if (out_fire) begin
                  if (k == OUT_LAST) begin
                     k     <= '0;
                     state <= ST_IDLE;
                  end else begin
                     k <= k + IW'(1);
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   rq_rot_mac #(
      .N    (N),
      .LOGQ (LOGQ),
      .IW   (IW)
   ) u_mac (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (clr),
      .ld_en    (in_fire),
      .ld_idx   (j),
      .ld_h     (in_h),
      .rot_en   (state == ST_MUL),
      .acc_en   (acc_en),
      .acc_neg  (acc_neg),
      .lift_en  (state == ST_LIFT),
      .lift_vec (lift_vec),
      .acc_vec  (acc_vec)
   );

endmodule

// File: tb/tb_encaps_rq_engine.sv
// Directed bench for encaps_rq_engine at N=5, LOGQ=4: one instance with DROP_LAST=0, one with 1.
// Latency: checks out_valid rises N+1 edges after the last accepted input beat.
// Backpressure: exercises input gaps and a 3-cycle output stall.
module tb_encaps_rq_engine;

   localparam logic [1:0] Z = 2'b00;
   localparam logic [1:0] P = 2'b01;
   localparam logic [1:0] M = 2'b10;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       mode;
   logic [3:0] in_h;
   logic [1:0] in_r;
   logic [1:0] in_m;
   logic       in_valid0, in_valid1;
   logic       out_ready0, out_ready1;

   logic       in_ready0, out_valid0, out_last0, busy0;
   logic [3:0] out_c0;
   logic       in_ready1, out_valid1, out_last1, busy1;
   logic [3:0] out_c1;

   logic       sel;
   logic       s_rdy, s_vld, s_last, s_busy;
   logic [3:0] s_c;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   assign s_rdy  = sel ? in_ready1  : in_ready0;
   assign s_vld  = sel ? out_valid1 : out_valid0;
   assign s_last = sel ? out_last1  : out_last0;
   assign s_busy = sel ? busy1      : busy0;
   assign s_c    = sel ? out_c1     : out_c0;

   encaps_rq_engine #(.N(5), .LOGQ(4), .DROP_LAST(0)) u_dut (
      .clk(clk), .rst_n(rst_n), .mode(mode),
      .in_valid(in_valid0), .in_ready(in_ready0),
      .in_h(in_h), .in_r(in_r), .in_m(in_m),
      .out_valid(out_valid0), .out_ready(out_ready0),
      .out_c(out_c0), .out_last(out_last0), .busy(busy0)
   );

   encaps_rq_engine #(.N(5), .LOGQ(4), .DROP_LAST(1)) u_drop (
      .clk(clk), .rst_n(rst_n), .mode(mode),
      .in_valid(in_valid1), .in_ready(in_ready1),
      .in_h(in_h), .in_r(in_r), .in_m(in_m),
      .out_valid(out_valid1), .out_ready(out_ready1),
      .out_c(out_c1), .out_last(out_last1), .busy(busy1)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic set_valid(input logic v);
      if (sel) in_valid1 = v;
      else     in_valid0 = v;
   endtask

   task automatic set_ordy(input logic v);
      if (sel) out_ready1 = v;
      else     out_ready0 = v;
   endtask

   // Coefficient b of each operand sits at the low end: h[b] = hp[b*4 +: 4], r[b] = rp[b*2 +: 2]
   task automatic send_poly(input logic [19:0] hp, input logic [9:0] rp, input logic [9:0] mp,
                            input logic md, input bit gaps, input bit flip);
      mode = md;
      for (int b = 0; b < 5; b++) begin
         in_h = hp[b*4 +: 4];
         in_r = rp[b*2 +: 2];
         in_m = mp[b*2 +: 2];
         set_valid(1'b1);
         chk($sformatf("in_ready_beat%0d", b), s_rdy, 1);
         @(posedge clk); #1;
         set_valid(1'b0);
         if (flip && b == 0) mode = ~md;
         if (gaps && b < 4) begin
            in_h = 4'hf; in_r = M; in_m = M;
            @(posedge clk); #1;
            chk($sformatf("in_ready_gap%0d", b), s_rdy, 1);
         end
      end
      mode = md;
   endtask

   // Called #1 after the last accepted beat's edge
   task automatic recv_check(input string tag, input logic [19:0] ep, input int nb, input bit stall);
      int cnt;
      int bad_rdy;
      cnt = 0;
      bad_rdy = s_rdy ? 1 : 0;
      while (!s_vld && cnt < 20) begin
         @(posedge clk); #1;
         cnt++;
         if (s_rdy) bad_rdy++;
      end
      chk({tag, "_latency"}, cnt, 6);
      chk({tag, "_in_ready_mul"}, bad_rdy, 0);
      for (int b = 0; b < nb; b++) begin
         if (stall && b == 2) begin
            set_ordy(1'b0);
            for (int s = 0; s < 3; s++) begin
               chk({tag, "_stall_c"}, s_c, ep[8 +: 4]);
               chk({tag, "_stall_vld"}, s_vld, 1);
               @(posedge clk); #1;
            end
            set_ordy(1'b1);
         end
         chk($sformatf("%s_c%0d", tag, b), s_c, ep[b*4 +: 4]);
         chk($sformatf("%s_vld%0d", tag, b), s_vld, 1);
         chk($sformatf("%s_last%0d", tag, b), s_last, (b == nb-1) ? 1 : 0);
         chk($sformatf("%s_in_ready_out%0d", tag, b), s_rdy, 0);
         @(posedge clk); #1;
      end
      chk({tag, "_busy_after"}, s_busy, 0);
      chk({tag, "_vld_after"}, s_vld, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [19:0] h_id;
      h_id = {4'd5, 4'd4, 4'd3, 4'd2, 4'd1};
      sel = 1'b0;
      rst_n = 1'b0;
      mode = 1'b0;
      in_h = '0; in_r = Z; in_m = Z;
      in_valid0 = 1'b0; in_valid1 = 1'b0;
      out_ready0 = 1'b1; out_ready1 = 1'b1;

      // Reset state
      #12;
      chk("rst_in_ready",  in_ready0,  0);
      chk("rst_out_valid", out_valid0, 0);
      chk("rst_out_c",     out_c0,     0);
      chk("rst_out_last",  out_last0,  0);
      chk("rst_busy",      busy0,      0);
      chk("rst_drop_busy", busy1,      0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("idle_in_ready", in_ready0, 1);

      // Identity: r = 1
      send_poly(h_id, {Z, Z, Z, Z, P}, {Z, Z, Z, Z, Z}, 1'b0, 0, 0);
      recv_check("ident", {4'd5, 4'd4, 4'd3, 4'd2, 4'd1}, 5, 0);

      // r = x rotates h by one
      send_poly(h_id, {Z, Z, Z, P, Z}, {Z, Z, Z, Z, Z}, 1'b0, 0, 0);
      recv_check("rot", {4'd4, 4'd3, 4'd2, 4'd1, 4'd5}, 5, 0);

      // r = -1 negates h
      send_poly(h_id, {Z, Z, Z, Z, M}, {Z, Z, Z, Z, Z}, 1'b0, 0, 0);
      recv_check("neg", {4'd11, 4'd12, 4'd13, 4'd14, 4'd15}, 5, 0);

      // mode 1 lift of m = 1: c = x - 1
      send_poly(20'd0, {Z, Z, Z, Z, Z}, {Z, Z, Z, Z, P}, 1'b1, 0, 0);
      recv_check("lift1", {4'd0, 4'd0, 4'd0, 4'd1, 4'd15}, 5, 0);

      // mode 0 plain ternary lift
      send_poly(20'd0, {Z, Z, Z, Z, Z}, {P, Z, Z, M, P}, 1'b0, 0, 0);
      recv_check("lift0", {4'd1, 4'd0, 4'd0, 4'd15, 4'd1}, 5, 0);

      // Mixed r = 1 - x, mode 1 with m = x; mode toggled after first beat must be ignored
      send_poly(h_id, {Z, Z, Z, M, P}, {Z, Z, Z, P, Z}, 1'b1, 0, 1);
      recv_check("mixed", {4'd1, 4'd1, 4'd2, 4'd0, 4'd12}, 5, 0);

      // Input gaps plus a 3-cycle output stall at k=2
      send_poly(h_id, {Z, Z, Z, Z, P}, {Z, Z, Z, Z, Z}, 1'b0, 1, 0);
      recv_check("stall", {4'd5, 4'd4, 4'd3, 4'd2, 4'd1}, 5, 1);

      // DROP_LAST instance: four beats only
      sel = 1'b1;
      send_poly(h_id, {Z, Z, Z, Z, P}, {Z, Z, Z, Z, Z}, 1'b0, 0, 0);
      recv_check("drop", {4'd0, 4'd4, 4'd3, 4'd2, 4'd1}, 4, 0);
      sel = 1'b0;

      // Reset during MUL cycle 2, with operands that would leave residue
      send_poly({4'd9, 4'd9, 4'd9, 4'd9, 4'd9}, {M, P, M, P, M}, {P, P, P, P, P}, 1'b1, 0, 0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("pre_abort_busy", busy0, 1);
      rst_n = 1'b0;
      #1;
      chk("abort_in_ready",  in_ready0,  0);
      chk("abort_out_valid", out_valid0, 0);
      chk("abort_out_c",     out_c0,     0);
      chk("abort_out_last",  out_last0,  0);
      chk("abort_busy",      busy0,      0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      send_poly(h_id, {Z, Z, Z, Z, P}, {Z, Z, Z, Z, Z}, 1'b0, 0, 0);
      recv_check("post_rst", {4'd5, 4'd4, 4'd3, 4'd2, 4'd1}, 5, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
